nonrestoring_sdiv: RTL and testbench

//  Sequential signed divider; inverse of the team's sequential Booth multiplier.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_sign_fix.sv | 51 +++++
 rtl/nonrestoring_sdiv.sv | 155 +++++++++++++++
 tb/tb_nonrestoring_sdiv.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the sequential signed divider.
// The optional quotient overflow check is controlled by DIV_OVF_CHECK_EN (see div_sign_fix).
package div_pkg;

    localparam int DIV_N     = 6;
    localparam int DIV_ITER  = 2 * DIV_N;
    localparam int DIV_CNT_W = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Turns the unsigned magnitude quotient/remainder into signed results.
// DIV_OVF_CHECK_EN defined: out-of-range quotients saturate and raise ovf; otherwise they wrap.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [2*N-1:0] q_mag_i,
    input  logic [N-1:0]   r_mag_i,
    input  logic           q_neg_i,
    input  logic           r_neg_i,
    input  logic           div_zero_i,
    output logic [N-1:0]   quot_o,
    output logic [N-1:0]   rem_o,
    output logic           ovf_o
);

    localparam logic [2*N-1:0] POS_LIM = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [2*N-1:0] NEG_LIM = POS_LIM + 1'b1;

    logic [2*N-1:0] q_wide;
    logic [N-1:0]   rem_signed;
    logic           too_big;
    logic           unused_q_hi;

    assign q_wide      = q_neg_i ? (~q_mag_i + 1'b1) : q_mag_i;
    assign rem_signed  = r_neg_i ? (~r_mag_i + 1'b1) : r_mag_i;
    assign too_big     = q_neg_i ? (q_mag_i > NEG_LIM) : (q_mag_i > POS_LIM);
    assign unused_q_hi = ^q_wide[2*N-1:N];

    always_comb begin
        quot_o = q_wide[N-1:0];
        rem_o  = rem_signed;
        ovf_o  = 1'b0;
`ifdef DIV_OVF_CHECK_EN
        if (too_big) begin
            quot_o = q_neg_i ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            ovf_o  = 1'b1;
        end
`else
        ovf_o = too_big & 1'b0;
`endif
        // A zero divisor overrides everything, including the overflow flag.
        if (div_zero_i) begin
            quot_o = '0;
            rem_o  = '0;
            ovf_o  = 1'b0;
        end
    end

endmodule

// File: rtl/nonrestoring_sdiv.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Overflow saturation is enabled by defining DIV_OVF_CHECK_EN.
module nonrestoring_sdiv
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf
);

    localparam int ITER  = 2 * N;
    localparam int CNT_W = $clog2(ITER + 1);

    div_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N:0]     r_q, r_d;
    logic [2*N-1:0] dq_q, dq_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic           sign_dd_q, sign_dd_d;
    logic           sign_dv_q, sign_dv_d;
    logic           dz_q, dz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dz_out_q, dz_out_d;
    logic           ovf_q, ovf_d;

    logic [N:0]     r_shift;
    logic           r_ge;
    logic [N-1:0]   fix_quot;
    logic [N-1:0]   fix_rem;
    logic           fix_ovf;
    logic           unused_r_msb;

    // The partial remainder stays below |divisor|, so its top bit only matters mid-shift.
    assign r_shift      = {r_q[N-1:0], dq_q[2*N-1]};
    assign r_ge         = (r_shift >= {1'b0, dvs_q});
    assign unused_r_msb = r_q[N];

    div_sign_fix #(.N(N)) u_sign_fix (
        .q_mag_i    (dq_q),
        .r_mag_i    (r_q[N-1:0]),
        .q_neg_i    (sign_dd_q ^ sign_dv_q),
        .r_neg_i    (sign_dd_q),
        .div_zero_i (dz_q),
        .quot_o     (fix_quot),
        .rem_o      (fix_rem),
        .ovf_o      (fix_ovf)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            r_q       <= '0;
            dq_q      <= '0;
            dvs_q     <= '0;
            sign_dd_q <= 1'b0;
            sign_dv_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_out_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            r_q       <= r_d;
            dq_q      <= dq_d;
            dvs_q     <= dvs_d;
            sign_dd_q <= sign_dd_d;
            sign_dv_q <= sign_dv_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dz_out_q  <= dz_out_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        r_d       = r_q;
        dq_d      = dq_q;
        dvs_d     = dvs_q;
        sign_dd_d = sign_dd_q;
        sign_dv_d = sign_dv_q;
        dz_d      = dz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dz_out_d  = dz_out_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CALC;
                    count_d   = CNT_W'(ITER);
                    r_d       = '0;
                    dq_d      = dividend[2*N-1] ? (~dividend + 1'b1) : dividend;
                    dvs_d     = divisor[N-1] ? (~divisor + 1'b1) : divisor;
                    sign_dd_d = dividend[2*N-1];
                    sign_dv_d = divisor[N-1];
                    dz_d      = (divisor == '0);
                    busy_d    = 1'b1;
                end
            end
            ST_CALC: begin
                r_d     = r_ge ? (r_shift - {1'b0, dvs_q}) : r_shift;
                dq_d    = {dq_q[2*N-2:0], r_ge};
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                quot_d   = fix_quot;
                rem_d    = fix_rem;
                dz_out_d = dz_q;
                ovf_d    = fix_ovf;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nonrestoring_sdiv.sv
// Scoreboard bench for nonrestoring_sdiv: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_nonrestoring_sdiv;

    localparam int N       = 6;
    localparam int LATENCY = 2 * N + 1;

    logic           clk;
    logic           n_rst;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_zero;
    logic           ovf;

    typedef struct {
        string name;
        int    q;
        int    r;
        int    dz;
        int    ov;
        int    t0;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    logic prev_done = 1'b0;

    nonrestoring_sdiv dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        total_cnt++;
        if (act == exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (n_rst && done) begin
            check("done_one_cycle", int'(prev_done), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_quotient"},  int'(quotient),  e.q);
                check({e.name, "_remainder"}, int'(remainder), e.r);
                check({e.name, "_div_zero"},  int'(div_zero),  e.dz);
                check({e.name, "_ovf"},       int'(ovf),       e.ov);
                check({e.name, "_latency"},   cyc - e.t0,      LATENCY);
                $display("result %s: q=0x%0h r=0x%0h dz=%0d ovf=%0d at cycle %0d",
                         e.name, quotient, remainder, div_zero, ovf, cyc);
            end
        end
        prev_done = done;
    end

    task automatic push_exp(input string name, input int q, input int r,
                            input int dz, input int ov);
        exp_t e;
        e.name = name;
        e.q    = q;
        e.r    = r;
        e.dz   = dz;
        e.ov   = ov;
        e.t0   = cyc;
        sb.push_back(e);
    endtask

    task automatic drive_op(input int dd, input int dv);
        logic [31:0] ddv;
        logic [31:0] dvv;
        ddv      = dd;
        dvv      = dv;
        dividend = ddv[2*N-1:0];
        divisor  = dvv[N-1:0];
    endtask

    // Issues one operation; the accept edge is the posedge after start is raised.
    task automatic issue(input string name, input int dd, input int dv, input int q,
                         input int r, input int dz, input int ov, input bit track);
        @(posedge clk); #1;
        drive_op(dd, dv);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (track) push_exp(name, q, r, dz, ov);
        check({name, "_busy"}, int'(busy), 1);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_done"},      int'(done),      0);
        check({tag, "_quotient"},  int'(quotient),  0);
        check({tag, "_remainder"}, int'(remainder), 0);
        check({tag, "_div_zero"},  int'(div_zero),  0);
        check({tag, "_ovf"},       int'(ovf),       0);
    endtask

    int ovf_q_big;
    int ovf_f_big;

    initial begin
`ifdef DIV_OVF_CHECK_EN
        ovf_q_big = 'h1F;
        ovf_f_big = 1;
`else
        ovf_q_big = 0;
        ovf_f_big = 0;
`endif
        n_rst    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        idle_cycles(3);
        #1;
        check_reset_outputs("reset");
        n_rst = 1'b1;
        idle_cycles(2);

        issue("p100_d7", 100, 7, 'h0E, 'h02, 0, 0, 1'b1);
        wait_done("p100_d7");
        issue("m100_d7", -100, 7, 'h32, 'h3E, 0, 0, 1'b1);
        wait_done("m100_d7");
        issue("p100_dm7", 100, -7, 'h32, 'h02, 0, 0, 1'b1);
        wait_done("p100_dm7");
        issue("m2048_dm32", -2048, -32, ovf_q_big, 0, 0, ovf_f_big, 1'b1);
        wait_done("m2048_dm32");
        issue("p55_d0", 55, 0, 0, 0, 1, 0, 1'b1);
        wait_done("p55_d0");
        issue("m7_d2", -7, 2, 'h3D, 'h3F, 0, 0, 1'b1);
        wait_done("m7_d2");
        issue("p31_dm32", 31, -32, 0, 'h1F, 0, 0, 1'b1);
        wait_done("p31_dm32");

        // A second start during an active op must neither disturb it nor queue.
        issue("ignored_start", 100, 7, 'h0E, 'h02, 0, 0, 1'b1);
        idle_cycles(4);
        #1;
        drive_op(55, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored_start");
        idle_cycles(20);

        // start held high: a new op begins the cycle after done.
        @(posedge clk); #1;
        drive_op(-100, 7);
        start = 1'b1;
        @(posedge clk); #1;
        push_exp("b2b_first", 'h32, 'h3E, 0, 0);
        wait_done("b2b_first");
        @(posedge clk); #1;
        push_exp("b2b_second", 'h32, 'h3E, 0, 0);
        start = 1'b0;
        wait_done("b2b_second");
        idle_cycles(2);

        // Reset mid-operation aborts with no done.
        issue("abort", 100, -7, 0, 0, 0, 0, 1'b0);
        idle_cycles(6);
        #1;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        idle_cycles(2);
        #1;
        n_rst = 1'b1;
        idle_cycles(20);
        issue("after_abort", 100, -7, 'h32, 'h02, 0, 0, 1'b1);
        wait_done("after_abort");
        idle_cycles(3);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
